// File: rtl/plic_multi.sv
// plic_multi: multi-context platform interrupt controller.
// Per-source priority and edge/level gateway, per-context enable, threshold
// and claim/complete, memory-mapped at BASE_ADDR on the CPU data bus.
module plic_multi #(
    parameter int unsigned NUM_SOURCES  = 32,
    parameter int unsigned NUM_CONTEXTS = 2,
    parameter int unsigned PRIO_BITS    = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h0C00_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wstrb,
    input  logic                    read_en,
    output logic [31:0]             rdata,
    output logic                    addr_valid,
    input  logic [NUM_SOURCES-1:0]  irq_sources,
    output logic [NUM_CONTEXTS-1:0] external_irq
);
    localparam int unsigned NW = (NUM_SOURCES + 31) / 32;
    localparam logic [NUM_SOURCES-1:0] SRC_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};

    logic [PRIO_BITS-1:0]   prio_q [NUM_SOURCES];
    logic [PRIO_BITS-1:0]   prio_d [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] en_q   [NUM_CONTEXTS];
    logic [NUM_SOURCES-1:0] en_d   [NUM_CONTEXTS];
    logic [PRIO_BITS-1:0]   thr_q  [NUM_CONTEXTS];
    logic [PRIO_BITS-1:0]   thr_d  [NUM_CONTEXTS];
    logic [NUM_SOURCES-1:0] pending_q, pending_d, in_flight_q, in_flight_d;
    logic [NUM_SOURCES-1:0] edge_held_q, edge_held_d, mode_q, mode_d, sampled_q;
    logic [NUM_SOURCES-1:0] rise, busy, held, claim_set, cpl_clr;
    logic [5:0]             best_id   [NUM_CONTEXTS];
    logic [PRIO_BITS-1:0]   best_prio [NUM_CONTEXTS];
    logic [NUM_CONTEXTS-1:0] irq_d;

    logic        hit, wr;
    logic [23:0] off;
    logic [9:0]  prio_idx;
    logic [4:0]  word, en_ctx;
    logic [3:0]  tc_ctx;
    logic        sel_prio, sel_pend, sel_mode, sel_en, sel_thr, sel_claim;

    // Selects one 32-bit word of a per-source vector; bit 0 always reads 0.
    function automatic logic [31:0] word_of(input logic [NUM_SOURCES-1:0] v, input logic hi);
        logic [63:0] pad;
        pad = '0;
        pad[NUM_SOURCES-1:0] = v;
        pad[0] = 1'b0;
        return hi ? pad[63:32] : pad[31:0];
    endfunction

    // Address decode of every implemented register.
    always_comb begin
        hit       = (addr[31:24] == BASE_ADDR[31:24]);
        off       = addr[23:0];
        prio_idx  = off[11:2];
        word      = off[6:2];
        en_ctx    = off[11:7];
        tc_ctx    = off[15:12];
        sel_prio  = 1'b0;
        sel_pend  = 1'b0;
        sel_mode  = 1'b0;
        sel_en    = 1'b0;
        sel_thr   = 1'b0;
        sel_claim = 1'b0;
        if (hit && off[1:0] == 2'b00) begin
            sel_prio  = (off[23:12] == 12'h000) && (prio_idx != '0) && (32'(prio_idx) < NUM_SOURCES);
            sel_pend  = (off[23:7] == 17'h00020) && (32'(word) < NW);
            sel_mode  = (off[23:7] == 17'h00021) && (32'(word) < NW);
            sel_en    = (off[23:12] == 12'h002) && (32'(en_ctx) < NUM_CONTEXTS) && (32'(word) < NW);
            sel_thr   = (off[23:16] == 8'h20) && (off[11:2] == 10'd0) && (32'(tc_ctx) < NUM_CONTEXTS);
            sel_claim = (off[23:16] == 8'h20) && (off[11:2] == 10'd1) && (32'(tc_ctx) < NUM_CONTEXTS);
        end
        addr_valid = sel_prio | sel_pend | sel_mode | sel_en | sel_thr | sel_claim;
    end

    // Per-context arbitration: highest priority wins, strict compare keeps the lowest ID on ties.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CONTEXTS; c++) begin
            best_id[c]   = '0;
            best_prio[c] = '0;
            for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
                if (pending_q[i] && en_q[c][i] && (prio_q[i] > thr_q[c]) && (prio_q[i] > best_prio[c])) begin
                    best_id[c]   = 6'(i);
                    best_prio[c] = prio_q[i];
                end
            end
            irq_d[c] = (best_id[c] != '0);
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata = '0;
        if (read_en) begin
            for (int unsigned i = 1; i < NUM_SOURCES; i++)
                if (sel_prio && 32'(prio_idx) == i) rdata = 32'(prio_q[i]);
            if (sel_pend) rdata = word_of(pending_q, word[0]);
            if (sel_mode) rdata = word_of(mode_q, word[0]);
            for (int unsigned c = 0; c < NUM_CONTEXTS; c++) begin
                if (sel_en && 32'(en_ctx) == c)    rdata = word_of(en_q[c], word[0]);
                if (sel_thr && 32'(tc_ctx) == c)   rdata = 32'(thr_q[c]);
                if (sel_claim && 32'(tc_ctx) == c) rdata = 32'(best_id[c]);
            end
        end
    end

    // Register writes, claim/complete side effects and the per-source gateway.
    always_comb begin
        wr        = |wstrb;
        prio_d    = prio_q;
        en_d      = en_q;
        thr_d     = thr_q;
        mode_d    = mode_q;
        claim_set = '0;
        cpl_clr   = '0;
        if (wr) begin
            for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
                if (sel_prio && 32'(prio_idx) == i)  prio_d[i] = wdata[PRIO_BITS-1:0];
                if (sel_mode && 32'(word) == i / 32) mode_d[i] = wdata[i % 32];
            end
            for (int unsigned c = 0; c < NUM_CONTEXTS; c++) begin
                for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
                    if (sel_en && 32'(en_ctx) == c && 32'(word) == i / 32) en_d[c][i] = wdata[i % 32];
                    if (sel_claim && 32'(tc_ctx) == c && wdata[5:0] == 6'(i) && in_flight_q[i] && en_q[c][i])
                        cpl_clr[i] = 1'b1;
                end
                if (sel_thr && 32'(tc_ctx) == c) thr_d[c] = wdata[PRIO_BITS-1:0];
            end
        end
        if (read_en) begin
            for (int unsigned c = 0; c < NUM_CONTEXTS; c++)
                for (int unsigned i = 1; i < NUM_SOURCES; i++)
                    if (sel_claim && 32'(tc_ctx) == c && best_id[c] == 6'(i)) claim_set[i] = 1'b1;
        end
        // An edge seen while pending or in flight is parked in edge_held; a claim in
        // the same cycle sees pending=1, so it parks too. Completion converts a
        // parked edge (including one arriving on that same cycle) into one pending.
        rise        = irq_sources & ~sampled_q;
        busy        = pending_q | in_flight_q;
        held        = edge_held_q | (mode_q & rise & busy);
        pending_d   = ((pending_q & ~claim_set)
                    | (~busy & ((mode_q & rise) | (~mode_q & irq_sources)))
                    | (cpl_clr & mode_q & held)) & SRC_MASK;
        in_flight_d = ((in_flight_q & ~cpl_clr) | claim_set) & SRC_MASK;
        edge_held_d = held & ~(cpl_clr & mode_q) & ~(mode_d ^ mode_q) & SRC_MASK;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= '{default: '0};
            en_q         <= '{default: '0};
            thr_q        <= '{default: '0};
            pending_q    <= '0;
            in_flight_q  <= '0;
            edge_held_q  <= '0;
            mode_q       <= '0;
            sampled_q    <= '0;
            external_irq <= '0;
        end else begin
            prio_q       <= prio_d;
            en_q         <= en_d;
            thr_q        <= thr_d;
            pending_q    <= pending_d;
            in_flight_q  <= in_flight_d;
            edge_held_q  <= edge_held_d;
            mode_q       <= mode_d & SRC_MASK;
            sampled_q    <= irq_sources & SRC_MASK;
            external_irq <= irq_d;
        end
    end
endmodule

// File: tb/tb_plic_multi.sv
// Self-checking bench for plic_multi: register-map table plus directed
// sequences for gateway, arbitration, claim/complete and reset behaviour.
`timescale 1ns/1ps
module tb_plic_multi;
    localparam logic [31:0] BASE = 32'h0C00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        read_en, addr_valid;
    logic [31:0] irq_sources;
    logic [1:0]  external_irq;

    plic_multi #(.NUM_SOURCES(32), .NUM_CONTEXTS(2), .PRIO_BITS(3), .BASE_ADDR(32'h0C00_0000)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .read_en(read_en), .rdata(rdata), .addr_valid(addr_valid),
        .irq_sources(irq_sources), .external_irq(external_irq)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        bit          wr;
        bit          rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        bit          exp_valid;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] a_prio(int id);      return BASE + 32'(4 * id); endfunction
    function automatic logic [31:0] a_pend();            return BASE + 32'h1000; endfunction
    function automatic logic [31:0] a_mode();            return BASE + 32'h1080; endfunction
    function automatic logic [31:0] a_en(int c);         return BASE + 32'h2000 + 32'(c * 32'h80); endfunction
    function automatic logic [31:0] a_thr(int c);        return BASE + 32'h200000 + 32'(c * 32'h1000); endfunction
    function automatic logic [31:0] a_claim(int c);      return BASE + 32'h200004 + 32'(c * 32'h1000); endfunction

    task automatic expect_val(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic compare_next(input logic [31:0] act);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wstrb = 4'hF;
        tick();
        wstrb = 4'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        addr = a; read_en = 1'b1;
        expect_val(name, exp);
        #1 compare_next(rdata);
        tick();
        read_en = 1'b0;
    endtask

    task automatic chk_ext(input logic [1:0] exp, input string name);
        expect_val(name, {30'd0, exp});
        compare_next({30'd0, external_irq});
    endtask

    task automatic pulse(input logic [31:0] m);
        @(negedge clk); irq_sources = irq_sources | m;
        tick();
        @(negedge clk); irq_sources = irq_sources & ~m;
        tick();
    endtask

    task automatic add_vec(input string n, input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] er, input bit ev);
        vec_t v;
        v.name = n; v.wr = w; v.rd = r; v.a = a; v.d = d; v.exp_rdata = er; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra [5];

        rst_n = 1'b0; addr = '0; wdata = '0; wstrb = '0; read_en = 1'b0; irq_sources = '0;
        #12 chk_ext(2'b00, "reset_ext");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Register map table: {name, write, read, addr, wdata, exp rdata, exp addr_valid}
        add_vec("prio5_wr",     1, 0, a_prio(5),           32'h7,        32'h0,        1);
        add_vec("prio5_rd",     0, 1, a_prio(5),           32'h0,        32'h7,        1);
        add_vec("prio5_noren",  0, 0, a_prio(5),           32'h0,        32'h0,        1);
        add_vec("prio5_wr_ff",  1, 0, a_prio(5),           32'hFF,       32'h0,        1);
        add_vec("prio5_trunc",  0, 1, a_prio(5),           32'h0,        32'h7,        1);
        add_vec("prio5_clr",    1, 0, a_prio(5),           32'h0,        32'h0,        1);
        add_vec("prio0_undec",  0, 1, a_prio(0),           32'h0,        32'h0,        0);
        add_vec("prio32_undec", 0, 1, a_prio(32),          32'h0,        32'h0,        0);
        add_vec("mode_wr1",     1, 0, a_mode(),            32'hFFFFFFFF, 32'h0,        1);
        add_vec("mode_rd1",     0, 1, a_mode(),            32'h0,        32'hFFFFFFFE, 1);
        add_vec("mode_wr0",     1, 0, a_mode(),            32'h0,        32'h0,        1);
        add_vec("mode_rd0",     0, 1, a_mode(),            32'h0,        32'h0,        1);
        add_vec("mode_w1_undec",0, 1, a_mode() + 32'h4,    32'h0,        32'h0,        0);
        add_vec("en1_wr",       1, 0, a_en(1),             32'hFFFFFFFF, 32'h0,        1);
        add_vec("en1_rd",       0, 1, a_en(1),             32'h0,        32'hFFFFFFFE, 1);
        add_vec("en1_clr",      1, 0, a_en(1),             32'h0,        32'h0,        1);
        add_vec("en2_undec",    0, 1, a_en(2),             32'h0,        32'h0,        0);
        add_vec("thr1_wr",      1, 0, a_thr(1),            32'hF,        32'h0,        1);
        add_vec("thr1_rd",      0, 1, a_thr(1),            32'h0,        32'h7,        1);
        add_vec("thr1_clr",     1, 0, a_thr(1),            32'h0,        32'h0,        1);
        add_vec("thr2_undec",   0, 1, a_thr(2),            32'h0,        32'h0,        0);
        add_vec("pend_wr",      1, 0, a_pend(),            32'hFFFF,     32'h0,        1);
        add_vec("pend_ro",      0, 1, a_pend(),            32'h0,        32'h0,        1);
        add_vec("bad_base",     0, 1, 32'h0D000004,        32'h0,        32'h0,        0);
        add_vec("claim0_idle",  0, 1, a_claim(0),          32'h0,        32'h0,        1);

        foreach (vecs[k]) begin
            @(negedge clk);
            addr = vecs[k].a; wdata = vecs[k].d;
            wstrb = vecs[k].wr ? 4'hF : 4'h0;
            read_en = vecs[k].rd;
            expect_val({vecs[k].name, "_valid"}, {31'd0, vecs[k].exp_valid});
            if (!vecs[k].wr) expect_val(vecs[k].name, vecs[k].exp_rdata);
            #1;
            compare_next({31'd0, addr_valid});
            if (!vecs[k].wr) compare_next(rdata);
            tick();
            wstrb = 4'h0; read_en = 1'b0;
        end

        // Single context, edge mode on source 3
        wr(a_prio(3), 32'd2);
        wr(a_en(0), 32'h8);
        wr(a_mode(), 32'h8);
        @(negedge clk); irq_sources[3] = 1'b1;
        tick();
        chk_ext(2'b00, "edge_lat1");
        @(negedge clk); irq_sources[3] = 1'b0;
        tick();
        chk_ext(2'b01, "edge_lat2");
        rd_chk(a_pend(), 32'h8, "edge_pend");
        rd_chk(a_claim(0), 32'd3, "edge_claim");
        rd_chk(a_pend(), 32'h0, "edge_pend_clr");
        rd_chk(a_claim(0), 32'd0, "edge_claim_again");
        wr(a_claim(0), 32'd3);
        pulse(32'h8);
        rd_chk(a_pend(), 32'h8, "edge_after_cpl");
        rd_chk(a_claim(0), 32'd3, "edge_claim2");
        wr(a_claim(1), 32'd3);              // ctx1 lacks enable: ignored
        pulse(32'h8);
        rd_chk(a_pend(), 32'h0, "cpl_wrong_ctx");
        wr(a_claim(0), 32'd3);              // releases the held edge
        rd_chk(a_pend(), 32'h8, "held_repend3");
        rd_chk(a_claim(0), 32'd3, "edge_claim3");
        wr(a_claim(0), 32'd3);
        rd_chk(a_claim(0), 32'd0, "edge_done");

        // Priority and tie-break (level mode sources 2,5,7)
        wr(a_prio(5), 32'd4);
        wr(a_prio(2), 32'd4);
        wr(a_prio(7), 32'd6);
        wr(a_en(0), 32'hAC);
        pulse(32'hA4);
        rd_chk(a_pend(), 32'hA4, "tie_pend");
        rd_chk(a_claim(0), 32'd7, "tie_claim7");
        rd_chk(a_claim(0), 32'd2, "tie_claim2");
        rd_chk(a_claim(0), 32'd5, "tie_claim5");
        rd_chk(a_claim(0), 32'd0, "tie_claim0");
        wr(a_claim(0), 32'd7);
        wr(a_claim(0), 32'd2);
        wr(a_claim(0), 32'd5);
        rd_chk(a_pend(), 32'h0, "tie_pend_done");

        // Threshold and context split on source 4
        wr(a_prio(4), 32'd3);
        wr(a_en(0), 32'hBC);
        wr(a_en(1), 32'h10);
        wr(a_thr(0), 32'd3);
        wr(a_thr(1), 32'd2);
        pulse(32'h10);
        chk_ext(2'b10, "thr_split");
        wr(a_thr(1), 32'd3);
        tick();
        chk_ext(2'b00, "thr_raise_drop");
        wr(a_thr(1), 32'd2);
        tick();
        chk_ext(2'b10, "thr_restore");
        rd_chk(a_claim(0), 32'd0, "thr_claim_ctx0");
        rd_chk(a_claim(1), 32'd4, "thr_claim_ctx1");
        wr(a_claim(1), 32'd4);
        wr(a_thr(0), 32'd0);
        rd_chk(a_pend(), 32'h0, "thr_pend_done");

        // Held edge on source 6, plus complete coinciding with a new edge
        wr(a_prio(6), 32'd5);
        wr(a_en(0), 32'hFC);
        wr(a_mode(), 32'h48);
        pulse(32'h40);
        rd_chk(a_claim(0), 32'd6, "held_claim");
        pulse(32'h40);
        pulse(32'h40);
        rd_chk(a_pend(), 32'h0, "held_pend_busy");
        wr(a_claim(0), 32'd6);
        rd_chk(a_pend(), 32'h40, "held_repend");
        rd_chk(a_claim(0), 32'd6, "held_claim2");
        @(negedge clk);
        addr = a_claim(0); wdata = 32'd6; wstrb = 4'hF; irq_sources[6] = 1'b1;
        tick();
        wstrb = 4'h0;
        @(negedge clk) irq_sources[6] = 1'b0;
        rd_chk(a_pend(), 32'h40, "sim_cpl_edge");
        rd_chk(a_claim(0), 32'd6, "sim_claim");
        wr(a_claim(0), 32'd6);
        rd_chk(a_pend(), 32'h0, "held_once");
        rd_chk(a_claim(0), 32'd0, "held_claim_none");

        // Level mode on source 9
        wr(a_prio(9), 32'd1);
        wr(a_en(0), 32'h2FC);
        @(negedge clk) irq_sources[9] = 1'b1;
        tick();
        tick();
        rd_chk(a_claim(0), 32'd9, "lvl_claim");
        wr(a_claim(0), 32'd9);
        rd_chk(a_pend(), 32'h0, "lvl_cpl_same");
        rd_chk(a_pend(), 32'h200, "lvl_repend");
        rd_chk(a_claim(0), 32'd9, "lvl_claim2");
        @(negedge clk) irq_sources[9] = 1'b0;
        wr(a_claim(0), 32'd9);
        tick();
        rd_chk(a_pend(), 32'h0, "lvl_no_repend");
        rd_chk(a_claim(0), 32'd0, "lvl_claim_none");

        // Reset in the middle of a claim
        pulse(32'h8);
        rd_chk(a_claim(0), 32'd3, "rst_claim3");
        @(negedge clk) irq_sources[9] = 1'b1;
        tick();
        tick();
        chk_ext(2'b01, "rst_pre_ext");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_ext(2'b00, "rst_async_ext");
        irq_sources = '0;
        read_en = 1'b1;
        ra[0] = a_prio(3); ra[1] = a_en(0); ra[2] = a_pend(); ra[3] = a_mode(); ra[4] = a_claim(0);
        for (int k = 0; k < 5; k++) begin
            addr = ra[k];
            expect_val($sformatf("rst_read%0d", k), 32'h0);
            #1 compare_next(rdata);
        end
        read_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        chk_ext(2'b00, "post_rst_ext");
        rd_chk(a_claim(0), 32'd0, "post_rst_claim");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
